// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: tracks in-flight destination/Tnew for E/M/W and raises the D-stage stall.
// Optional MDU busy-time interlock is compiled in when MDU_STALL_EN is defined.
module hazard_scoreboard #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       d_valid,
    input  logic [4:0] d_rs,
    input  logic [4:0] d_rt,
    input  logic [1:0] d_tuse_rs,
    input  logic [1:0] d_tuse_rt,
    input  logic [4:0] d_a3,
    input  logic [1:0] d_tnew,
    input  logic       d_md_start,
    input  logic       d_md_div,
    input  logic       d_md_use,
    input  logic       pipe_flush,
    output logic       stall,
    output logic       flush_e,
    output logic [4:0] e_a3,
    output logic [4:0] m_a3,
    output logic [4:0] w_a3,
    output logic       e_rdy,
    output logic       m_rdy,
    output logic       md_busy
);

    logic [4:0] e_a3_q, m_a3_q, w_a3_q;
    logic [1:0] e_tnew_q, m_tnew_q;
    logic [4:0] e_a3_d, m_a3_d, w_a3_d;
    logic [1:0] e_tnew_d, m_tnew_d;
    logic       md_stall;
    logic       accept;
    logic       any_hit;

    function automatic logic src_hit(input logic [4:0] x_a3, input logic [1:0] x_tnew,
                                     input logic [4:0] src, input logic [1:0] tuse);
        return (x_a3 == src) && (src != 5'd0) && (x_tnew > tuse);
    endfunction

    function automatic logic [1:0] dec_sat(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    always_comb begin
        any_hit = src_hit(e_a3_q, e_tnew_q, d_rs, d_tuse_rs)
                | src_hit(m_a3_q, m_tnew_q, d_rs, d_tuse_rs)
                | src_hit(e_a3_q, e_tnew_q, d_rt, d_tuse_rt)
                | src_hit(m_a3_q, m_tnew_q, d_rt, d_tuse_rt);
    end

    assign stall   = d_valid & (any_hit | md_stall);
    assign flush_e = stall | pipe_flush;
    assign accept  = d_valid & ~stall & ~pipe_flush;

    always_comb begin
        e_a3_d   = accept ? d_a3   : 5'd0;
        e_tnew_d = accept ? d_tnew : 2'd0;
        m_a3_d   = pipe_flush ? 5'd0 : e_a3_q;
        m_tnew_d = pipe_flush ? 2'd0 : dec_sat(e_tnew_q);
        // W only needs the destination: its Tnew can never cause a stall.
        w_a3_d   = m_a3_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_a3_q   <= 5'd0;
            m_a3_q   <= 5'd0;
            w_a3_q   <= 5'd0;
            e_tnew_q <= 2'd0;
            m_tnew_q <= 2'd0;
        end else begin
            e_a3_q   <= e_a3_d;
            m_a3_q   <= m_a3_d;
            w_a3_q   <= w_a3_d;
            e_tnew_q <= e_tnew_d;
            m_tnew_q <= m_tnew_d;
        end
    end

`ifdef MDU_STALL_EN
    logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
    logic             e_md_q, e_md_d;

    always_comb begin
        md_cnt_d = md_cnt_q;
        if (accept && d_md_start)
            md_cnt_d = d_md_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        else if (md_cnt_q != '0)
            md_cnt_d = md_cnt_q - 1'b1;
        e_md_d = accept & d_md_start;
    end

    // A loaded counter survives pipe_flush; only the E flag is squashed with E.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_q <= '0;
            e_md_q   <= 1'b0;
        end else begin
            md_cnt_q <= md_cnt_d;
            e_md_q   <= e_md_d;
        end
    end

    assign md_busy  = (md_cnt_q != '0);
    assign md_stall = d_md_use & (md_busy | e_md_q);
`else
    logic md_unused;
    assign md_unused = ^{d_md_start, d_md_div, d_md_use, CNT_W'(MULT_CYCLES), CNT_W'(DIV_CYCLES)};
    assign md_busy   = 1'b0;
    assign md_stall  = 1'b0;
`endif

    assign e_a3  = e_a3_q;
    assign m_a3  = m_a3_q;
    assign w_a3  = w_a3_q;
    assign e_rdy = (e_tnew_q == 2'd0);
    assign m_rdy = (m_tnew_q == 2'd0);

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: vector table for the pipeline flow plus
// hand-written sequences for async reset and (with MDU_STALL_EN) the MDU interlock.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       d_valid = 1'b0;
    logic [4:0] d_rs = 5'd0, d_rt = 5'd0, d_a3 = 5'd0;
    logic [1:0] d_tuse_rs = 2'd3, d_tuse_rt = 2'd3, d_tnew = 2'd0;
    logic       d_md_start = 1'b0, d_md_div = 1'b0, d_md_use = 1'b0;
    logic       pipe_flush = 1'b0;
    logic       stall, flush_e, e_rdy, m_rdy, md_busy;
    logic [4:0] e_a3, m_a3, w_a3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid), .d_rs(d_rs), .d_rt(d_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_a3(d_a3), .d_tnew(d_tnew),
        .d_md_start(d_md_start), .d_md_div(d_md_div), .d_md_use(d_md_use),
        .pipe_flush(pipe_flush), .stall(stall), .flush_e(flush_e),
        .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3), .e_rdy(e_rdy), .m_rdy(m_rdy),
        .md_busy(md_busy)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs, rt;
        logic [1:0] tuse_rs, tuse_rt;
        logic [4:0] a3;
        logic [1:0] tnew;
        logic       flush;
        logic       x_stall, x_flush_e;
        logic [4:0] x_e, x_m, x_w;
        logic       x_erdy, x_mrdy;
    } vec_t;

    vec_t vecs[23];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                         input logic [4:0] rt, input logic [1:0] trt,
                         input logic [4:0] a3, input logic [1:0] tn, input logic fl);
        d_valid = v; d_rs = rs; d_tuse_rs = trs; d_rt = rt; d_tuse_rt = trt;
        d_a3 = a3; d_tnew = tn; pipe_flush = fl;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        set_d(1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, 1'b0);
        d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic v, input logic [4:0] rs, input logic [1:0] trs,
                                input logic [4:0] rt, input logic [1:0] trt,
                                input logic [4:0] a3, input logic [1:0] tn, input logic fl,
                                input logic xs, input logic xf, input logic [4:0] xe,
                                input logic [4:0] xm, input logic [4:0] xw,
                                input logic xer, input logic xmr);
        vec_t r;
        r.valid = v; r.rs = rs; r.tuse_rs = trs; r.rt = rt; r.tuse_rt = trt;
        r.a3 = a3; r.tnew = tn; r.flush = fl;
        r.x_stall = xs; r.x_flush_e = xf; r.x_e = xe; r.x_m = xm; r.x_w = xw;
        r.x_erdy = xer; r.x_mrdy = xmr;
        return r;
    endfunction

    initial begin
        //               v rs trs rt trt a3 tn fl | st fe  e  m  w er mr
        vecs[0]  = mk(1, 0, 3, 0, 3,  1, 2, 0,  0, 0,  0, 0, 0, 1, 1); // lw $1
        vecs[1]  = mk(1, 1, 1, 0, 3,  4, 1, 0,  1, 1,  1, 0, 0, 0, 1); // add uses $1 -> stall
        vecs[2]  = mk(1, 1, 1, 0, 3,  4, 1, 0,  0, 0,  0, 1, 0, 1, 0); // accepted
        vecs[3]  = mk(1, 0, 3, 0, 3,  2, 1, 0,  0, 0,  4, 0, 1, 0, 1); // add $2
        vecs[4]  = mk(1, 2, 0, 0, 3,  0, 0, 0,  1, 1,  2, 4, 0, 0, 1); // beq $2 -> stall
        vecs[5]  = mk(1, 2, 0, 0, 3,  0, 0, 0,  0, 0,  0, 2, 4, 1, 1); // accepted, m_rdy=1
        vecs[6]  = mk(1, 0, 3, 0, 3,  0, 2, 0,  0, 0,  0, 0, 2, 1, 1); // $0 producer
        vecs[7]  = mk(1, 0, 0, 0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0, 1); // $0 consumer: no stall
        vecs[8]  = mk(1, 0, 3, 0, 3,  7, 2, 0,  0, 0,  0, 0, 0, 1, 0); // lw $7
        vecs[9]  = mk(1, 0, 3, 7, 2,  0, 0, 0,  0, 0,  7, 0, 0, 0, 1); // sw rt=$7 tuse2: ok
        vecs[10] = mk(1, 0, 3, 0, 3,  0, 0, 0,  0, 0,  0, 7, 0, 1, 0); // sw (a3=0)
        vecs[11] = mk(1, 0, 3, 0, 3,  3, 2, 0,  0, 0,  0, 0, 7, 1, 1); // lw $3
        vecs[12] = mk(1, 3, 1, 0, 3,  8, 1, 1,  1, 1,  3, 0, 0, 0, 1); // stall + flush
        vecs[13] = mk(1, 3, 1, 0, 3,  8, 1, 0,  0, 0,  0, 0, 0, 1, 1); // stall cleared
        vecs[14] = mk(1, 0, 3, 0, 3,  9, 3, 0,  0, 0,  8, 0, 0, 0, 1); // tnew=3 producer
        vecs[15] = mk(1, 0, 3, 0, 3, 10, 1, 1,  0, 1,  9, 8, 0, 0, 1); // flush, M commits
        vecs[16] = mk(0, 0, 3, 0, 3,  0, 0, 0,  0, 0,  0, 0, 8, 1, 1); // W kept M's $8
        vecs[17] = mk(1, 0, 3, 0, 3, 11, 3, 0,  0, 0,  0, 0, 0, 1, 1); // tnew=3 $11
        vecs[18] = mk(1,11, 1, 0, 3, 12, 1, 0,  1, 1, 11, 0, 0, 0, 1); // E hit 3>1
        vecs[19] = mk(1,11, 1, 0, 3, 12, 1, 0,  1, 1,  0,11, 0, 1, 0); // M hit 2>1
        vecs[20] = mk(1,11, 1, 0, 3, 12, 1, 0,  0, 0,  0, 0,11, 1, 1); // W ignored
        vecs[21] = mk(0,12, 0, 0, 3,  0, 0, 0,  0, 0, 12, 0, 0, 0, 1); // bubble: no stall
        vecs[22] = mk(0, 0, 3, 0, 3,  0, 0, 0,  0, 0,  0,12, 0, 1, 1);

        // Reset state while reset_n is low
        #2;
        check("rst_e_a3", e_a3, 0);
        check("rst_m_a3", m_a3, 0);
        check("rst_w_a3", w_a3, 0);
        check("rst_e_rdy", e_rdy, 1);
        check("rst_m_rdy", m_rdy, 1);
        check("rst_md_busy", md_busy, 0);
        check("rst_stall", stall, 0);
        do_reset();

        for (int i = 0; i < 23; i++) begin
            set_d(vecs[i].valid, vecs[i].rs, vecs[i].tuse_rs, vecs[i].rt, vecs[i].tuse_rt,
                  vecs[i].a3, vecs[i].tnew, vecs[i].flush);
            #1;
            $display("vec %0d: stall=%0d flush_e=%0d e=%0d m=%0d w=%0d erdy=%0d mrdy=%0d",
                     i, stall, flush_e, e_a3, m_a3, w_a3, e_rdy, m_rdy);
            check($sformatf("v%0d_stall", i), stall, vecs[i].x_stall);
            check($sformatf("v%0d_flush_e", i), flush_e, vecs[i].x_flush_e);
            check($sformatf("v%0d_e_a3", i), e_a3, vecs[i].x_e);
            check($sformatf("v%0d_m_a3", i), m_a3, vecs[i].x_m);
            check($sformatf("v%0d_w_a3", i), w_a3, vecs[i].x_w);
            check($sformatf("v%0d_e_rdy", i), e_rdy, vecs[i].x_erdy);
            check($sformatf("v%0d_m_rdy", i), m_rdy, vecs[i].x_mrdy);
            @(negedge clk);
        end

        // Async reset in the middle of a stall on $5
        set_d(1, 0, 3, 0, 3, 5, 2, 0);
        @(negedge clk);
        set_d(1, 5, 0, 0, 3, 6, 1, 0);
        #1;
        check("pre_rst_stall", stall, 1);
        check("pre_rst_e_a3", e_a3, 5);
        #1 reset_n = 1'b0;
        #1;
        $display("async reset: stall=%0d e=%0d m=%0d w=%0d", stall, e_a3, m_a3, w_a3);
        check("arst_stall", stall, 0);
        check("arst_e_a3", e_a3, 0);
        check("arst_m_a3", m_a3, 0);
        check("arst_w_a3", w_a3, 0);
        do_reset();

`ifdef MDU_STALL_EN
        for (int k = 0; k < 2; k++) begin
            int stalls;
            int exp_stalls;
            exp_stalls = (k == 0) ? 10 : 5;
            stalls = 0;
            set_d(1, 0, 3, 0, 3, 0, 0, 0);
            d_md_start = 1'b1; d_md_div = (k == 0);
            @(negedge clk);
            d_md_start = 1'b0; d_md_div = 1'b0; d_md_use = 1'b1;
            #1;
            check($sformatf("md%0d_busy", k), md_busy, 1);
            while (stall && stalls < 30) begin
                stalls++;
                @(negedge clk);
                #1;
            end
            $display("mdu %s: stalled %0d cycles", (k == 0) ? "div" : "mult", stalls);
            check($sformatf("md%0d_stall_cycles", k), stalls, exp_stalls);
            check($sformatf("md%0d_busy_end", k), md_busy, 0);
            @(negedge clk);
            d_md_use = 1'b0;
            set_d(0, 0, 3, 0, 3, 0, 0, 0);
            @(negedge clk);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
